sys_ctrl: RTL and testbench
===========================

SYS_CTRL -- requirements
Module: sys_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, command/data byte width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, register-file address width.
REQ-003 SHALL have port CLK  input  1  single system clock; all state on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port RX_P_DATA  input  DATA_WIDTH  received command/operand byte.
REQ-006 SHALL have port RX_D_VLD  input  1  one-cycle strobe: RX_P_DATA valid.
REQ-007 SHALL have port RdData  input  DATA_WIDTH  register-file read data.
REQ-008 SHALL have port RdData_VLD  input  1  register-file read-data valid strobe.
REQ-009 SHALL have port ALU_OUT  input  2*DATA_WIDTH  ALU result.
REQ-010 SHALL have port ALU_OUT_VLD  input  1  ALU result valid strobe.
REQ-011 SHALL have port FIFO_FULL  input  1  TX FIFO full; no TX write while high.
REQ-012 SHALL have port WrEn  output  1  register-file write strobe.
REQ-013 SHALL have port RdEn  output  1  register-file read strobe.
REQ-014 SHALL have port Address  output  ADDR_WIDTH  register-file address.
REQ-015 SHALL have port WrData  output  DATA_WIDTH  register-file write data.
REQ-016 SHALL have port ALU_EN  output  1  ALU start strobe.
REQ-017 SHALL have port ALU_FUN  output  4  ALU function select.
REQ-018 SHALL have port CLK_EN  output  1  ALU clock-gate enable.
REQ-019 SHALL have port TX_P_DATA  output  DATA_WIDTH  byte to TX FIFO.
REQ-020 SHALL have port TX_D_VLD  output  1  TX FIFO write strobe.

Function
REQ-021 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD, OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI.
REQ-022 All outputs SHALL be registered; every strobe (WrEn, RdEn, ALU_EN, TX_D_VLD) SHALL be high for exactly one cycle.
REQ-023 IDLE on RX_D_VLD: 0xAA->WR_ADDR, 0xBB->RD_ADDR, 0xCC->OPA, 0xDD->FUN; any other byte ignored, stay IDLE.
REQ-024 WR_ADDR on RX_D_VLD: latch RX_P_DATA[ADDR_WIDTH-1:0] as address -> WR_DATA.
REQ-025 WR_DATA on RX_D_VLD: next cycle WrEn=1, Address=latched, WrData=RX_P_DATA -> IDLE.
REQ-026 RD_ADDR on RX_D_VLD: next cycle RdEn=1, Address=RX_P_DATA[ADDR_WIDTH-1:0] -> RD_WAIT.
REQ-027 RD_WAIT: on RdData_VLD capture RdData -> TX_RD; wait indefinitely otherwise.
REQ-028 TX_RD: when FIFO_FULL=0, TX_D_VLD=1 with captured byte -> IDLE; while FIFO_FULL=1 hold state, TX_D_VLD=0.
REQ-029 OPA on RX_D_VLD: WrEn pulse, Address=0, WrData=byte -> OPB; OPB same with Address=1 -> FUN.
REQ-030 FUN on RX_D_VLD: ALU_FUN=RX_P_DATA[3:0] (held until next FUN), ALU_EN pulse -> ALU_WAIT.
REQ-031 CLK_EN SHALL be 1 in FUN and ALU_WAIT, and SHALL be 0 in all other states.
REQ-032 ALU_WAIT: on ALU_OUT_VLD capture ALU_OUT -> TX_LO; TX_LO sends bits [DATA_WIDTH-1:0], then TX_HI sends upper byte, each gated by FIFO_FULL=0.
REQ-033 RX_D_VLD in RD_WAIT, TX_RD, ALU_WAIT, TX_LO, TX_HI SHALL be ignored (byte dropped).
REQ-034 WrEn and RdEn SHALL never be high in the same cycle.
REQ-035 Address and WrData SHALL hold last driven value when no strobe is active.

Reset
REQ-036 RST low SHALL immediately force IDLE, all strobes 0, CLK_EN=0, Address/WrData/ALU_FUN/TX_P_DATA=0, captured registers cleared, including mid-command.
REQ-037 After RST release, first accepted byte SHALL be decoded as a command in IDLE.

Verification
REQ-038 RX 0xAA,0x05,0x3C -> one WrEn pulse, Address=5, WrData=0x3C; FSM back in IDLE.
REQ-039 RX 0xBB,0x02; RdData_VLD with RdData=0x81 -> one RdEn pulse Address=2, then TX_D_VLD with TX_P_DATA=0x81.
REQ-040 RX 0xCC,0x10,0x20,0x01; ALU_OUT=0x1234 valid -> WrEn at Address 0 (0x10) and 1 (0x20), ALU_EN with ALU_FUN=1, TX bytes 0x34 then 0x12; CLK_EN high only FUN..ALU_WAIT.
REQ-041 RX 0xDD,0x02 with FIFO_FULL=1 for 5 cycles after result -> no TX_D_VLD while full, both bytes sent in order after release.
REQ-042 RX 0x55 in IDLE -> no strobes; RX 0xAA,0x03 then RST low -> IDLE, no WrEn, all outputs reset values.

Source files
------------

// File: rtl/sys_ctrl.sv
// sys_ctrl: command-decoding controller between a UART-style RX byte stream,
// a register file, an ALU and a TX FIFO.
//
// Commands (first byte decoded in IDLE):
//   0xAA addr data        -> register-file write
//   0xBB addr             -> register-file read, read byte returned on TX
//   0xCC opA opB fun      -> write opA/opB to regs 0/1, start ALU, send result
//   0xDD fun              -> start ALU on current regs 0/1, send result
//
// Ports:
//   CLK, RST (async, active-low)
//   RX_P_DATA/RX_D_VLD          : incoming byte + one-cycle strobe
//   RdData/RdData_VLD           : register-file read return
//   ALU_OUT/ALU_OUT_VLD         : ALU result return
//   FIFO_FULL                   : TX FIFO back-pressure
//   WrEn/RdEn/Address/WrData    : register-file access
//   ALU_EN/ALU_FUN/CLK_EN       : ALU start, function, clock-gate enable
//   TX_P_DATA/TX_D_VLD          : byte to TX FIFO
//
// Every output comes straight from a flop; next-state values are computed
// one cycle ahead in the combinational process.
module sys_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RX_P_DATA,
  input  logic                    RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]   RdData,
  input  logic                    RdData_VLD,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_OUT_VLD,
  input  logic                    FIFO_FULL,
  output logic                    WrEn,
  output logic                    RdEn,
  output logic [ADDR_WIDTH-1:0]   Address,
  output logic [DATA_WIDTH-1:0]   WrData,
  output logic                    ALU_EN,
  output logic [3:0]              ALU_FUN,
  output logic                    CLK_EN,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_D_VLD
);

  localparam logic [DATA_WIDTH-1:0] CMD_WR  = DATA_WIDTH'(8'hAA);
  localparam logic [DATA_WIDTH-1:0] CMD_RD  = DATA_WIDTH'(8'hBB);
  localparam logic [DATA_WIDTH-1:0] CMD_OP  = DATA_WIDTH'(8'hCC);
  localparam logic [DATA_WIDTH-1:0] CMD_FUN = DATA_WIDTH'(8'hDD);

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_RD,
    OPA, OPB, FUN, ALU_WAIT, TX_LO, TX_HI
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    wren_q, wren_d, rden_q, rden_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wrdata_q, wrdata_d;
  logic                    alu_en_q, alu_en_d;
  logic [3:0]              alu_fun_q, alu_fun_d;
  logic                    clk_en_q, clk_en_d;
  logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
  logic                    tx_vld_q, tx_vld_d;
  logic [DATA_WIDTH-1:0]   rd_cap_q, rd_cap_d;
  logic [2*DATA_WIDTH-1:0] alu_cap_q, alu_cap_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      wr_addr_q <= '0;
      wren_q    <= 1'b0;
      rden_q    <= 1'b0;
      address_q <= '0;
      wrdata_q  <= '0;
      alu_en_q  <= 1'b0;
      alu_fun_q <= '0;
      clk_en_q  <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q  <= 1'b0;
      rd_cap_q  <= '0;
      alu_cap_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      wren_q    <= wren_d;
      rden_q    <= rden_d;
      address_q <= address_d;
      wrdata_q  <= wrdata_d;
      alu_en_q  <= alu_en_d;
      alu_fun_q <= alu_fun_d;
      clk_en_q  <= clk_en_d;
      tx_data_q <= tx_data_d;
      tx_vld_q  <= tx_vld_d;
      rd_cap_q  <= rd_cap_d;
      alu_cap_q <= alu_cap_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    wren_d    = 1'b0;
    rden_d    = 1'b0;
    address_d = address_q;
    wrdata_d  = wrdata_q;
    alu_en_d  = 1'b0;
    alu_fun_d = alu_fun_q;
    tx_data_d = tx_data_q;
    tx_vld_d  = 1'b0;
    rd_cap_d  = rd_cap_q;
    alu_cap_d = alu_cap_q;

    case (state_q)
      IDLE: if (RX_D_VLD) begin
        case (RX_P_DATA)
          CMD_WR:  state_d = WR_ADDR;
          CMD_RD:  state_d = RD_ADDR;
          CMD_OP:  state_d = OPA;
          CMD_FUN: state_d = FUN;
          default: state_d = IDLE;
        endcase
      end
      WR_ADDR: if (RX_D_VLD) begin
        wr_addr_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = WR_DATA;
      end
      WR_DATA: if (RX_D_VLD) begin
        wren_d    = 1'b1;
        address_d = wr_addr_q;
        wrdata_d  = RX_P_DATA;
        state_d   = IDLE;
      end
      RD_ADDR: if (RX_D_VLD) begin
        rden_d    = 1'b1;
        address_d = RX_P_DATA[ADDR_WIDTH-1:0];
        state_d   = RD_WAIT;
      end
      RD_WAIT: if (RdData_VLD) begin
        rd_cap_d = RdData;
        state_d  = TX_RD;
      end
      TX_RD: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = rd_cap_q;
        state_d   = IDLE;
      end
      OPA: if (RX_D_VLD) begin
        wren_d    = 1'b1;
        address_d = ADDR_WIDTH'(0);
        wrdata_d  = RX_P_DATA;
        state_d   = OPB;
      end
      OPB: if (RX_D_VLD) begin
        wren_d    = 1'b1;
        address_d = ADDR_WIDTH'(1);
        wrdata_d  = RX_P_DATA;
        state_d   = FUN;
      end
      FUN: if (RX_D_VLD) begin
        alu_fun_d = RX_P_DATA[3:0];
        alu_en_d  = 1'b1;
        state_d   = ALU_WAIT;
      end
      ALU_WAIT: if (ALU_OUT_VLD) begin
        alu_cap_d = ALU_OUT;
        state_d   = TX_LO;
      end
      TX_LO: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = alu_cap_q[DATA_WIDTH-1:0];
        state_d   = TX_HI;
      end
      TX_HI: if (!FIFO_FULL) begin
        tx_vld_d  = 1'b1;
        tx_data_d = alu_cap_q[2*DATA_WIDTH-1:DATA_WIDTH];
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Registered from the next state so the gate is open exactly while the
    // FSM sits in FUN or ALU_WAIT.
    clk_en_d = (state_d == FUN) || (state_d == ALU_WAIT);
  end

  assign WrEn      = wren_q;
  assign RdEn      = rden_q;
  assign Address   = address_q;
  assign WrData    = wrdata_q;
  assign ALU_EN    = alu_en_q;
  assign ALU_FUN   = alu_fun_q;
  assign CLK_EN    = clk_en_q;
  assign TX_P_DATA = tx_data_q;
  assign TX_D_VLD  = tx_vld_q;

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: expected strobe events are queued when the
// stimulus is driven and popped by a negedge monitor as the DUT emits them.
module tb_sys_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] RX_P_DATA = '0;
  logic          RX_D_VLD = 1'b0;
  logic [DW-1:0] RdData = '0;
  logic          RdData_VLD = 1'b0;
  logic [2*DW-1:0] ALU_OUT = '0;
  logic          ALU_OUT_VLD = 1'b0;
  logic          FIFO_FULL = 1'b0;
  logic          WrEn, RdEn, ALU_EN, CLK_EN, TX_D_VLD;
  logic [AW-1:0] Address;
  logic [DW-1:0] WrData, TX_P_DATA;
  logic [3:0]    ALU_FUN;

  sys_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_VLD(RdData_VLD),
    .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
    .FIFO_FULL(FIFO_FULL),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_EN(CLK_EN),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
  );

  always #5 CLK = ~CLK;

  int asserts = 0;
  int fails   = 0;
  int tx_cnt  = 0;
  logic tx_blocked = 1'b0;
  logic [15:0] expq[$];

  // Event encoding: {kind, addr/fun, data}
  function automatic logic [15:0] ev_wr(input logic [3:0] a, input logic [7:0] d);
    return {4'h1, a, d};
  endfunction
  function automatic logic [15:0] ev_rd(input logic [3:0] a);
    return {4'h2, a, 8'h00};
  endfunction
  function automatic logic [15:0] ev_alu(input logic [3:0] f);
    return {4'h3, f, 8'h00};
  endfunction
  function automatic logic [15:0] ev_tx(input logic [7:0] d);
    return {4'h4, 4'h0, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    asserts++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [15:0] obs);
    logic [15:0] e;
    if (expq.size() == 0) begin
      check({tag, "_unexpected"}, {16'h0, obs}, 32'hFFFF_FFFF);
    end else begin
      e = expq.pop_front();
      check(tag, {16'h0, obs}, {16'h0, e});
    end
  endtask

  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn)     pop_cmp("wren",   {4'h1, Address, WrData});
      if (RdEn)     pop_cmp("rden",   {4'h2, Address, 8'h00});
      if (ALU_EN)   pop_cmp("alu_en", {4'h3, ALU_FUN, 8'h00});
      if (TX_D_VLD) begin
        tx_cnt++;
        pop_cmp("tx", {4'h4, 4'h0, TX_P_DATA});
        check("tx_while_full", {31'h0, tx_blocked}, 32'h0);
      end
      if (WrEn || RdEn) check("wr_rd_excl", {31'h0, WrEn & RdEn}, 32'h0);
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge CLK); #1;
    RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(posedge CLK); #1;
    RX_D_VLD = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (expq.size() != 0 && n < 50) begin
      @(posedge CLK);
      n++;
    end
    #1;
    check(tag, expq.size(), 32'h0);
  endtask

  function automatic logic [31:0] out_pack();
    return {3'b0, WrEn, RdEn, ALU_EN, TX_D_VLD, CLK_EN, Address, WrData, ALU_FUN, TX_P_DATA};
  endfunction

  initial begin
    int snap;
    // Reset state
    @(negedge CLK);
    check("reset_outputs", out_pack(), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // Register write
    expq.push_back(ev_wr(4'h5, 8'h3C));
    send(8'hAA); send(8'h05); send(8'h3C);
    drain("wr_done");

    // Register read returned on TX
    expq.push_back(ev_rd(4'h2));
    expq.push_back(ev_tx(8'h81));
    send(8'hBB); send(8'h02);
    cycles(2);
    RdData = 8'h81; RdData_VLD = 1'b1;
    cycles(1);
    RdData_VLD = 1'b0; RdData = 8'h00;
    drain("rd_done");

    // Operands + function, result sent low byte first
    expq.push_back(ev_wr(4'h0, 8'h10));
    expq.push_back(ev_wr(4'h1, 8'h20));
    expq.push_back(ev_alu(4'h1));
    expq.push_back(ev_tx(8'h34));
    expq.push_back(ev_tx(8'h12));
    check("clk_en_idle", {31'h0, CLK_EN}, 32'h0);
    send(8'hCC); send(8'h10);
    check("clk_en_opb", {31'h0, CLK_EN}, 32'h0);
    send(8'h20);
    check("clk_en_fun", {31'h0, CLK_EN}, 32'h1);
    send(8'h01);
    check("clk_en_alu_wait", {31'h0, CLK_EN}, 32'h1);
    cycles(2);
    ALU_OUT = 16'h1234; ALU_OUT_VLD = 1'b1;
    cycles(1);
    ALU_OUT_VLD = 1'b0;
    check("clk_en_tx_lo", {31'h0, CLK_EN}, 32'h0);
    drain("op_done");
    check("alu_fun_held", {28'h0, ALU_FUN}, 32'h1);

    // Function-only command, FIFO back-pressure, byte dropped in ALU_WAIT
    expq.push_back(ev_alu(4'h2));
    expq.push_back(ev_tx(8'hEF));
    expq.push_back(ev_tx(8'hBE));
    send(8'hDD); send(8'h02);
    send(8'hAA);
    FIFO_FULL = 1'b1; tx_blocked = 1'b1;
    ALU_OUT = 16'hBEEF; ALU_OUT_VLD = 1'b1;
    cycles(1);
    ALU_OUT_VLD = 1'b0;
    snap = tx_cnt;
    cycles(5);
    check("no_tx_while_full", tx_cnt, snap);
    check("pending_tx", expq.size(), 32'h2);
    FIFO_FULL = 1'b0; tx_blocked = 1'b0;
    drain("full_done");

    // Unknown byte ignored
    send(8'h55);
    cycles(3);
    check("bad_cmd", expq.size(), 32'h0);

    // Reset mid-command
    send(8'hAA); send(8'h03);
    RST = 1'b0;
    @(negedge CLK);
    check("midcmd_reset", out_pack(), 32'h0);
    cycles(2);
    check("reset_held", out_pack(), 32'h0);
    @(negedge CLK);
    RST = 1'b1;

    // First byte after reset decoded as a command
    expq.push_back(ev_wr(4'h7, 8'h99));
    send(8'hAA); send(8'h07); send(8'h99);
    drain("post_reset_wr");
    cycles(3);
    check("final_queue", expq.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

endmodule
